// File: rtl/register_file_sb_if.sv
// Register file bus: two write ports, a reserve/flush control, and two combinational read ports.
//
// Handshake semantics: there is no valid/ready pair on this bus. we0, we1, rsv_en and flush are
// single-cycle qualifiers that the slave always accepts at the rising edge they are sampled on.
// Reads are combinational: rdN and rdN_busy follow raN in the same cycle. busy_count is registered.
interface register_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic                  we0;
    logic [AW-1:0]         wa0;
    logic [DATA_WIDTH-1:0] wd0;
    logic                  we1;
    logic [AW-1:0]         wa1;
    logic [DATA_WIDTH-1:0] wd1;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_addr;
    logic                  flush;
    logic [AW-1:0]         ra0;
    logic [DATA_WIDTH-1:0] rd0;
    logic                  rd0_busy;
    logic [AW-1:0]         ra1;
    logic [DATA_WIDTH-1:0] rd1;
    logic                  rd1_busy;
    logic [AW:0]           busy_count;

    modport master (
        output we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr, flush, ra0, ra1,
        input  rd0, rd0_busy, rd1, rd1_busy, busy_count
    );

    modport slave (
        input  we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr, flush, ra0, ra1,
        output rd0, rd0_busy, rd1, rd1_busy, busy_count
    );
endinterface

// File: rtl/register_file_sb.sv
// Two-write, two-read register file with optional write-to-read bypass and a per-register
// busy scoreboard (reserve / clear-on-write / flush) with a maintained busy counter.
module register_file_sb #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGS     = 32,
    parameter int BYPASS       = 1,
    parameter int RESET_PRESET = 1
) (
    input logic              clk,
    input logic              rst,
    register_file_sb_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [AW:0]           count;
    logic [AW:0]           count_next;
    logic                  inc;
    logic                  dec0;
    logic                  dec1;

    function automatic logic [DATA_WIDTH-1:0] preset_value(input int r);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        if (RESET_PRESET != 0) begin
            if (r == 1)  v = DATA_WIDTH'(10);
            if (r == 2)  v = DATA_WIDTH'(5);
            if (r == 10) v = DATA_WIDTH'(100);
        end
        return v;
    endfunction

    // Register storage: reset preset, otherwise port 1 overrides port 0 on a shared address.
    always_ff @(posedge clk) begin
        regs[0] <= '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (rst) begin
                regs[r] <= preset_value(r);
            end else if (bus.we1 && bus.wa1 == AW'(r)) begin
                regs[r] <= bus.wd1;
            end else if (bus.we0 && bus.wa0 == AW'(r)) begin
                regs[r] <= bus.wd0;
            end
        end
    end

    // Next busy vector: flush beats reserve, reserve beats clear-on-write, else hold.
    always_comb begin
        busy_next = busy;
        busy_next[0] = 1'b0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (bus.flush) begin
                busy_next[r] = 1'b0;
            end else if (bus.rsv_en && bus.rsv_addr == AW'(r)) begin
                busy_next[r] = 1'b1;
            end else if ((bus.we0 && bus.wa0 == AW'(r)) || (bus.we1 && bus.wa1 == AW'(r))) begin
                busy_next[r] = 1'b0;
            end
        end
    end

    // Counter deltas: only real 0->1 and 1->0 transitions move the count; a register cleared
    // by both ports counts once, and a register re-reserved while written stays busy.
    always_comb begin
        inc  = !bus.flush && bus.rsv_en && bus.rsv_addr != '0 && !busy[bus.rsv_addr];
        dec0 = !bus.flush && bus.we0 && bus.wa0 != '0 && busy[bus.wa0]
               && !(bus.rsv_en && bus.rsv_addr == bus.wa0);
        dec1 = !bus.flush && bus.we1 && bus.wa1 != '0 && busy[bus.wa1]
               && !(bus.rsv_en && bus.rsv_addr == bus.wa1)
               && !(bus.we0 && bus.wa0 == bus.wa1);
        if (bus.flush) begin
            count_next = '0;
        end else begin
            count_next = count + (AW+1)'(inc) - (AW+1)'(dec0) - (AW+1)'(dec1);
        end
    end

    // Scoreboard state: reset clears everything and discards same-cycle events.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_next;
            count <= count_next;
        end
    end

    // Read port A: stored value, optionally forwarded from a same-cycle write (port 1 first).
    always_comb begin
        bus.rd0      = regs[bus.ra0];
        bus.rd0_busy = busy[bus.ra0];
        if (BYPASS != 0) begin
            if (bus.we1 && bus.wa1 == bus.ra0) begin
                bus.rd0      = bus.wd1;
                bus.rd0_busy = 1'b0;
            end else if (bus.we0 && bus.wa0 == bus.ra0) begin
                bus.rd0      = bus.wd0;
                bus.rd0_busy = 1'b0;
            end
        end
        if (bus.ra0 == '0) begin
            bus.rd0      = '0;
            bus.rd0_busy = 1'b0;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        bus.rd1      = regs[bus.ra1];
        bus.rd1_busy = busy[bus.ra1];
        if (BYPASS != 0) begin
            if (bus.we1 && bus.wa1 == bus.ra1) begin
                bus.rd1      = bus.wd1;
                bus.rd1_busy = 1'b0;
            end else if (bus.we0 && bus.wa0 == bus.ra1) begin
                bus.rd1      = bus.wd0;
                bus.rd1_busy = 1'b0;
            end
        end
        if (bus.ra1 == '0) begin
            bus.rd1      = '0;
            bus.rd1_busy = 1'b0;
        end
    end

    assign bus.busy_count = count;
endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: one bypassing and one non-bypassing instance share the same
// stimulus and are checked against an array-based model of registers and busy bits.
module tb_register_file_sb;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = $clog2(NR);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];

    register_file_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus_a ();
    register_file_sb_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus_b ();

    register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(1), .RESET_PRESET(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    register_file_sb #(.DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(0), .RESET_PRESET(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    // clock / mirror bus_a stimulus onto bus_b
    always #5 clk = ~clk;
    assign bus_b.we0 = bus_a.we0;
    assign bus_b.wa0 = bus_a.wa0;
    assign bus_b.wd0 = bus_a.wd0;
    assign bus_b.we1 = bus_a.we1;
    assign bus_b.wa1 = bus_a.wa1;
    assign bus_b.wd1 = bus_a.wd1;
    assign bus_b.rsv_en = bus_a.rsv_en;
    assign bus_b.rsv_addr = bus_a.rsv_addr;
    assign bus_b.flush = bus_a.flush;
    assign bus_b.ra0 = bus_a.ra0;
    assign bus_b.ra1 = bus_a.ra1;

    function automatic logic [DW-1:0] preset(input int r);
        return (r == 1) ? DW'(10) : (r == 2) ? DW'(5) : (r == 10) ? DW'(100) : '0;
    endfunction

    function automatic int popcount();
        int c = 0;
        for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
        return c;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && bus_a.we1 && bus_a.wa1 == a) return bus_a.wd1;
        if (byp && bus_a.we0 && bus_a.wa0 == a) return bus_a.wd0;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((bus_a.we1 && bus_a.wa1 == a) || (bus_a.we0 && bus_a.wa0 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        bus_a.we0 = 0; bus_a.wa0 = '0; bus_a.wd0 = '0;
        bus_a.we1 = 0; bus_a.wa1 = '0; bus_a.wd1 = '0;
        bus_a.rsv_en = 0; bus_a.rsv_addr = '0; bus_a.flush = 0;
        rst = 0;
    endtask

    // Model step from the current inputs, then advance one edge.
    task automatic tick();
        logic [DW-1:0] nr [NR];
        bit nb [NR];
        nr = m_regs;
        nb = m_busy;
        for (int r = 1; r < NR; r++) begin
            if (rst) begin
                nr[r] = preset(r);
                nb[r] = 0;
            end else begin
                if (bus_a.we1 && bus_a.wa1 == r) nr[r] = bus_a.wd1;
                else if (bus_a.we0 && bus_a.wa0 == r) nr[r] = bus_a.wd0;
                if (bus_a.flush) nb[r] = 0;
                else if (bus_a.rsv_en && bus_a.rsv_addr == r) nb[r] = 1;
                else if ((bus_a.we0 && bus_a.wa0 == r) || (bus_a.we1 && bus_a.wa1 == r)) nb[r] = 0;
            end
        end
        nr[0] = '0;
        nb[0] = 0;
        @(posedge clk);
        #1;
        m_regs = nr;
        m_busy = nb;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        idle();
        bus_a.ra0 = 1; bus_a.ra1 = 10;
        #1;
        n_cmp++; if (bus_a.rd0 !== 16'd10) begin n_fail++; $display("FAIL reset_x1 got %0d want 10", bus_a.rd0); end
        n_cmp++; if (bus_a.rd1 !== 16'd100) begin n_fail++; $display("FAIL reset_x10 got %0d want 100", bus_a.rd1); end
        n_cmp++; if ({bus_a.rd0_busy, bus_a.rd1_busy, bus_b.rd0_busy, bus_b.rd1_busy} !== 4'b0)
            begin n_fail++; $display("FAIL reset_busy got %b want 0000", {bus_a.rd0_busy, bus_a.rd1_busy, bus_b.rd0_busy, bus_b.rd1_busy}); end
        n_cmp++; if (bus_a.busy_count !== '0 || bus_b.busy_count !== '0)
            begin n_fail++; $display("FAIL reset_count got %0d/%0d want 0", bus_a.busy_count, bus_b.busy_count); end
        bus_a.ra0 = 2;
        #1;
        n_cmp++; if (bus_a.rd0 !== 16'd5 || bus_b.rd0 !== 16'd5)
            begin n_fail++; $display("FAIL reset_x2 got %0d/%0d want 5", bus_a.rd0, bus_b.rd0); end
    endtask

    task automatic test_collision();
        bus_a.we0 = 1; bus_a.wa0 = 5; bus_a.wd0 = 16'h11;
        bus_a.we1 = 1; bus_a.wa1 = 5; bus_a.wd1 = 16'h22;
        tick();
        idle();
        bus_a.ra0 = 5;
        #1;
        n_cmp++; if (bus_a.rd0 !== 16'h22 || bus_b.rd0 !== 16'h22)
            begin n_fail++; $display("FAIL collision got %h/%h want 0022", bus_a.rd0, bus_b.rd0); end
        bus_a.we0 = 1; bus_a.wa0 = 0; bus_a.wd0 = 16'hFF; bus_a.ra0 = 0;
        #1;
        n_cmp++; if (bus_a.rd0 !== '0) begin n_fail++; $display("FAIL x0_bypass got %h want 0", bus_a.rd0); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus_a.rd0 !== '0 || bus_b.rd0 !== '0)
            begin n_fail++; $display("FAIL x0_write got %h/%h want 0", bus_a.rd0, bus_b.rd0); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old;
        old = m_regs[3];
        bus_a.we0 = 1; bus_a.wa0 = 3; bus_a.wd0 = 16'hABCD; bus_a.ra0 = 3;
        #1;
        n_cmp++; if (bus_a.rd0 !== 16'hABCD || bus_a.rd0_busy !== 1'b0)
            begin n_fail++; $display("FAIL bypass_on got %h busy %b want abcd busy 0", bus_a.rd0, bus_a.rd0_busy); end
        n_cmp++; if (bus_b.rd0 !== old)
            begin n_fail++; $display("FAIL bypass_off got %h want %h", bus_b.rd0, old); end
        tick();
        idle();
        #1;
        n_cmp++; if (bus_b.rd0 !== 16'hABCD)
            begin n_fail++; $display("FAIL bypass_off_next got %h want abcd", bus_b.rd0); end
    endtask

    task automatic test_scoreboard();
        int want [3] = '{1, 2, 2};
        logic [AW-1:0] seq [3] = '{4'd4, 4'd7, 4'd4};
        for (int i = 0; i < 3; i++) begin
            bus_a.rsv_en = 1; bus_a.rsv_addr = seq[i];
            tick();
            idle();
            n_cmp++; if (int'(bus_a.busy_count) != want[i] || int'(bus_b.busy_count) != want[i])
                begin n_fail++; $display("FAIL rsv_count%0d got %0d/%0d want %0d", i, bus_a.busy_count, bus_b.busy_count, want[i]); end
        end
        bus_a.we0 = 1; bus_a.wa0 = 7; bus_a.wd0 = 16'h77;
        tick();
        idle();
        bus_a.ra1 = 7;
        #1;
        n_cmp++; if (bus_a.rd1_busy !== 1'b0 || bus_b.rd1_busy !== 1'b0)
            begin n_fail++; $display("FAIL write_clears got %b/%b want 0", bus_a.rd1_busy, bus_b.rd1_busy); end
        n_cmp++; if (bus_a.busy_count !== 5'd1)
            begin n_fail++; $display("FAIL write_count got %0d want 1", bus_a.busy_count); end
    endtask

    task automatic test_simultaneous();
        bus_a.rsv_en = 1; bus_a.rsv_addr = 6;
        bus_a.we0 = 1; bus_a.wa0 = 6; bus_a.wd0 = 16'd9;
        tick();
        idle();
        bus_a.ra0 = 6;
        #1;
        n_cmp++; if (bus_a.rd0 !== 16'd9 || bus_a.rd0_busy !== 1'b1 || bus_b.rd0_busy !== 1'b1)
            begin n_fail++; $display("FAIL rsv_and_write got %0d busy %b/%b want 9 busy 1", bus_a.rd0, bus_a.rd0_busy, bus_b.rd0_busy); end
        n_cmp++; if (bus_a.busy_count !== 5'd2)
            begin n_fail++; $display("FAIL rsv_and_write_count got %0d want 2", bus_a.busy_count); end
        bus_a.flush = 1; bus_a.rsv_en = 1; bus_a.rsv_addr = 8;
        tick();
        idle();
        bus_a.ra0 = 8; bus_a.ra1 = 6;
        #1;
        n_cmp++; if (bus_a.busy_count !== '0 || bus_a.rd0_busy !== 1'b0 || bus_a.rd1_busy !== 1'b0)
            begin n_fail++; $display("FAIL flush got count %0d busy %b%b want 0 00", bus_a.busy_count, bus_a.rd0_busy, bus_a.rd1_busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bus_a.we0 = 1'($urandom_range(0, 1)); bus_a.wa0 = AW'($urandom); bus_a.wd0 = DW'($urandom);
            bus_a.we1 = 1'($urandom_range(0, 1)); bus_a.wa1 = AW'($urandom); bus_a.wd1 = DW'($urandom);
            bus_a.rsv_en = ($urandom_range(0, 2) != 0); bus_a.rsv_addr = AW'($urandom);
            bus_a.flush = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 59) == 0);
            bus_a.ra0 = ($urandom_range(0, 1) != 0) ? bus_a.wa0 : AW'($urandom);
            bus_a.ra1 = ($urandom_range(0, 1) != 0) ? bus_a.wa1 : AW'($urandom);
            #1;
            n_cmp++; if (bus_a.rd0 !== exp_rd(bus_a.ra0, 1) || bus_a.rd0_busy !== exp_busy(bus_a.ra0, 1))
                begin n_fail++; $display("FAIL rnd_a_rd0 i=%0d got %h/%b want %h/%b", i, bus_a.rd0, bus_a.rd0_busy, exp_rd(bus_a.ra0, 1), exp_busy(bus_a.ra0, 1)); end
            n_cmp++; if (bus_a.rd1 !== exp_rd(bus_a.ra1, 1) || bus_a.rd1_busy !== exp_busy(bus_a.ra1, 1))
                begin n_fail++; $display("FAIL rnd_a_rd1 i=%0d got %h/%b want %h/%b", i, bus_a.rd1, bus_a.rd1_busy, exp_rd(bus_a.ra1, 1), exp_busy(bus_a.ra1, 1)); end
            n_cmp++; if (bus_b.rd0 !== exp_rd(bus_a.ra0, 0) || bus_b.rd0_busy !== exp_busy(bus_a.ra0, 0))
                begin n_fail++; $display("FAIL rnd_b_rd0 i=%0d got %h/%b want %h/%b", i, bus_b.rd0, bus_b.rd0_busy, exp_rd(bus_a.ra0, 0), exp_busy(bus_a.ra0, 0)); end
            n_cmp++; if (bus_b.rd1 !== exp_rd(bus_a.ra1, 0) || bus_b.rd1_busy !== exp_busy(bus_a.ra1, 0))
                begin n_fail++; $display("FAIL rnd_b_rd1 i=%0d got %h/%b want %h/%b", i, bus_b.rd1, bus_b.rd1_busy, exp_rd(bus_a.ra1, 0), exp_busy(bus_a.ra1, 0)); end
            n_cmp++; if (int'(bus_a.busy_count) != popcount() || int'(bus_b.busy_count) != popcount())
                begin n_fail++; $display("FAIL rnd_count i=%0d got %0d/%0d want %0d", i, bus_a.busy_count, bus_b.busy_count, popcount()); end
            tick();
        end
        idle();
    endtask

    task automatic test_midreset();
        for (int r = 1; r <= 3; r++) begin
            bus_a.rsv_en = 1; bus_a.rsv_addr = AW'(r);
            tick();
        end
        idle();
        n_cmp++; if (int'(bus_a.busy_count) != popcount())
            begin n_fail++; $display("FAIL pre_reset_count got %0d want %0d", bus_a.busy_count, popcount()); end
        bus_a.we0 = 1; bus_a.wa0 = 1; bus_a.wd0 = 16'd77;
        rst = 1;
        tick();
        idle();
        bus_a.ra0 = 1; bus_a.ra1 = 2;
        #1;
        n_cmp++; if (bus_a.busy_count !== '0 || bus_b.busy_count !== '0)
            begin n_fail++; $display("FAIL midreset_count got %0d/%0d want 0", bus_a.busy_count, bus_b.busy_count); end
        n_cmp++; if (bus_a.rd0 !== 16'd10 || bus_b.rd0 !== 16'd10 || bus_a.rd1 !== 16'd5)
            begin n_fail++; $display("FAIL midreset_data got %0d/%0d/%0d want 10/10/5", bus_a.rd0, bus_b.rd0, bus_a.rd1); end
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 0;
        end
        idle();
        bus_a.ra0 = '0; bus_a.ra1 = '0;
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
